counter_readback: RTL

COUNTER_READBACK -- requirements
Module: counter_readback

---
 rtl/counter_readback.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/counter_readback.sv
// Counter 0 read-back path: control-word decode, count/status latching and
// byte-serialised CPU reads of a 16-bit count with a registered data bus.
module counter_readback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        ctrl_wr,
    input  logic [7:0]  ctrl_word,
    input  logic        rd,
    input  logic [15:0] live_count,
    input  logic        out_pin,
    input  logic        null_count,
    output logic [7:0]  data_out,
    output logic        data_oe
);

    typedef enum logic {
        PTR_LSB = 1'b0,
        PTR_MSB = 1'b1
    } ptr_t;

    localparam logic [1:0] SEL_CNT0     = 2'b00;
    localparam logic [1:0] SEL_READBACK = 2'b11;
    localparam logic [1:0] RW_LATCH     = 2'b00;
    localparam logic [1:0] RW_LSB       = 2'b01;
    localparam logic [1:0] RW_MSB       = 2'b10;
    localparam logic [1:0] RW_BOTH      = 2'b11;

    logic        rd_q, rd_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic        cnt_latched_q, cnt_latched_d;
    logic [15:0] latch_q, latch_d;
    logic        st_latched_q, st_latched_d;
    logic [7:0]  status_q, status_d;
    ptr_t        ptr_q, ptr_d;
    logic [7:0]  data_q, data_d;
    logic        oe_q, oe_d;

    logic        read_event;
    logic        ctrl_hit;
    logic        prog_wr;
    logic        latch_cmd;
    logic        rb_cmd;
    logic        rb_count;
    logic        rb_status;
    logic [15:0] count_src;

    // Decode the strobes: a read is the first cycle of rd while selected, and
    // the control word splits into programming, latch and read-back commands.
    always_comb begin
        read_event = cs & rd & ~rd_q;
        ctrl_hit   = ctrl_wr & cs;
        prog_wr    = ctrl_hit & (ctrl_word[7:6] == SEL_CNT0) & (ctrl_word[5:4] != RW_LATCH);
        latch_cmd  = ctrl_hit & (ctrl_word[7:6] == SEL_CNT0) & (ctrl_word[5:4] == RW_LATCH);
        rb_cmd     = ctrl_hit & (ctrl_word[7:6] == SEL_READBACK) & ctrl_word[1];
        rb_count   = rb_cmd & ~ctrl_word[5];
        rb_status  = rb_cmd & ~ctrl_word[4];
        count_src  = cnt_latched_q ? latch_q : live_count;
    end

    // Next-state logic: control writes win over a coincident read, which is
    // dropped so the data bus holds its previous byte.
    always_comb begin
        rd_d          = rd;
        oe_d          = cs & rd;
        rw_d          = rw_q;
        mode_d        = mode_q;
        bcd_d         = bcd_q;
        cnt_latched_d = cnt_latched_q;
        latch_d       = latch_q;
        st_latched_d  = st_latched_q;
        status_d      = status_q;
        ptr_d         = ptr_q;
        data_d        = data_q;

        if (prog_wr) begin
            rw_d          = ctrl_word[5:4];
            mode_d        = ctrl_word[3:1];
            bcd_d         = ctrl_word[0];
            cnt_latched_d = 1'b0;
            st_latched_d  = 1'b0;
            ptr_d         = PTR_LSB;
        end else begin
            if ((latch_cmd | rb_count) & ~cnt_latched_q) begin
                latch_d       = live_count;
                cnt_latched_d = 1'b1;
            end
            if (rb_status & ~st_latched_q) begin
                status_d     = {out_pin, null_count, rw_q, mode_q, bcd_q};
                st_latched_d = 1'b1;
            end
        end

        if (read_event & ~ctrl_wr) begin
            if (st_latched_q) begin
                data_d       = status_q;
                st_latched_d = 1'b0;
            end else begin
                case (rw_q)
                    RW_LSB: begin
                        data_d        = count_src[7:0];
                        cnt_latched_d = 1'b0;
                    end
                    RW_MSB: begin
                        data_d        = count_src[15:8];
                        cnt_latched_d = 1'b0;
                    end
                    RW_BOTH: begin
                        if (ptr_q == PTR_LSB) begin
                            data_d = count_src[7:0];
                            ptr_d  = PTR_MSB;
                        end else begin
                            data_d        = count_src[15:8];
                            ptr_d         = PTR_LSB;
                            cnt_latched_d = 1'b0;
                        end
                    end
                    default: begin
                        data_d = data_q;
                    end
                endcase
            end
        end
    end

    // State register with asynchronous reset to the power-up programming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q          <= 1'b0;
            oe_q          <= 1'b0;
            rw_q          <= RW_BOTH;
            mode_q        <= 3'b000;
            bcd_q         <= 1'b0;
            cnt_latched_q <= 1'b0;
            latch_q       <= 16'h0000;
            st_latched_q  <= 1'b0;
            status_q      <= 8'h00;
            ptr_q         <= PTR_LSB;
            data_q        <= 8'h00;
        end else begin
            rd_q          <= rd_d;
            oe_q          <= oe_d;
            rw_q          <= rw_d;
            mode_q        <= mode_d;
            bcd_q         <= bcd_d;
            cnt_latched_q <= cnt_latched_d;
            latch_q       <= latch_d;
            st_latched_q  <= st_latched_d;
            status_q      <= status_d;
            ptr_q         <= ptr_d;
            data_q        <= data_d;
        end
    end

    assign data_out = data_q;
    assign data_oe  = oe_q;

endmodule
